// File: rtl/word_memory_sequencer_pkg.sv
// Shared encodings for the word memory sequencer: FSM states, request
// field values and the beat wait counter width.
package mem_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BEAT0 = 2'b01,
    BEAT1 = 2'b10,
    DONE  = 2'b11
  } state_e;

  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_WORD = 1'b1;
  localparam logic RD        = 1'b0;
  localparam logic WR        = 1'b1;

  localparam int CNT_W = 3;

endpackage

// File: rtl/word_memory_sequencer_if.sv
// Request/response bus between the control unit and the sequencer, plus the
// byte-wide memory port the sequencer drives.
interface word_memory_sequencer_if;

  logic        Req;
  logic        Write;
  logic        Size;
  logic [15:0] Addr;
  logic [15:0] WData;
  logic        Ready;
  logic        Done;
  logic [15:0] RData;
  logic [15:0] MemAddr;
  logic        MemEn;
  logic        MemWr;
  logic [7:0]  MemDOut;
  logic [7:0]  MemDIn;

  modport master (
    output Req, Write, Size, Addr, WData, MemDIn,
    input  Ready, Done, RData, MemAddr, MemEn, MemWr, MemDOut
  );

  modport slave (
    input  Req, Write, Size, Addr, WData, MemDIn,
    output Ready, Done, RData, MemAddr, MemEn, MemWr, MemDOut
  );

endinterface

// File: rtl/word_memory_sequencer_beat_wait_counter.sv
// Down-counter that stretches each memory beat; Last marks the final cycle
// of the beat. Reloaded at the start of every beat.
module beat_wait_counter
  import mem_seq_pkg::*;
(
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Load,
  input  logic [CNT_W-1:0] LoadValue,
  input  logic             Decrement,
  output logic             Last
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      count_q <= '0;
    end else if (Load) begin
      count_q <= LoadValue;
    end else if (Decrement && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign Last = (count_q == '0);

endmodule

// File: rtl/word_memory_sequencer.sv
// Runs byte or 16-bit word accesses on a byte-wide memory: one or two beats,
// each held WAIT_CYCLES+1 cycles, then a one-cycle Done pulse.
module word_memory_sequencer
  import mem_seq_pkg::*;
#(
  parameter int WAIT_CYCLES   = 0,
  parameter bit LITTLE_ENDIAN = 1'b1
) (
  input  logic                    Clock,
  input  logic                    Reset,
  word_memory_sequencer_if.slave  bus
);

  localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);

  state_e      state_q, state_d;
  logic        wr_q;
  logic        size_q;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic [15:0] rdata_q;
  logic        accept;
  logic        cnt_load;
  logic        in_beat;
  logic        last;
  logic        hi_slot;

  beat_wait_counter u_wait (
    .Clock     (Clock),
    .Reset     (Reset),
    .Load      (cnt_load),
    .LoadValue (WAIT_LD),
    .Decrement (in_beat),
    .Last      (last)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    cnt_load = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.Req) begin
          accept   = 1'b1;
          cnt_load = 1'b1;
          state_d  = BEAT0;
        end
      end
      BEAT0: begin
        if (last) begin
          if (size_q == SIZE_WORD) begin
            cnt_load = 1'b1;
            state_d  = BEAT1;
          end else begin
            state_d = DONE;
          end
        end
      end
      BEAT1: begin
        if (last) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The first beat maps to the high byte only for big-endian words; the
  // second beat always takes the other half.
  always_comb begin
    in_beat = (state_q == BEAT0) || (state_q == BEAT1);
    hi_slot = (state_q == BEAT1) ? LITTLE_ENDIAN
                                 : (!LITTLE_ENDIAN && (size_q == SIZE_WORD));
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_q    <= RD;
      size_q  <= SIZE_BYTE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        wr_q    <= bus.Write;
        size_q  <= bus.Size;
        addr_q  <= bus.Addr;
        wdata_q <= bus.WData;
      end
      if (in_beat && last && (wr_q == RD)) begin
        if (size_q == SIZE_BYTE) begin
          rdata_q <= {8'h00, bus.MemDIn};
        end else if (hi_slot) begin
          rdata_q[15:8] <= bus.MemDIn;
        end else begin
          rdata_q[7:0] <= bus.MemDIn;
        end
      end
    end
  end

  assign bus.Ready   = (state_q == IDLE);
  assign bus.Done    = (state_q == DONE);
  assign bus.RData   = rdata_q;
  assign bus.MemAddr = (state_q == BEAT1) ? (addr_q + 16'd1) : addr_q;
  assign bus.MemEn   = in_beat;
  assign bus.MemWr   = in_beat && (wr_q == WR);
  assign bus.MemDOut = hi_slot ? wdata_q[15:8] : wdata_q[7:0];

endmodule
